// File: rtl/instr_cache_ctrl_pkg.sv
// Shared widths, constants and state encodings
// for the direct-mapped instruction cache.
package instr_cache_ctrl_pkg;

  localparam int DEF_LINES = 16;
  localparam int DEF_WORDS = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BYTE_W    = 2;
  localparam int CNT_W     = 16;

  localparam logic [DATA_W-1:0] NOP = 32'h00000013;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  function automatic int tag_width(input int lines, input int words);
    return ADDR_W - BYTE_W - $clog2(lines) - $clog2(words);
  endfunction

endpackage

// File: rtl/instr_cache_ctrl_array.sv
// Tag, valid and data storage: one synchronous
// write port, one combinational read port.
module icache_array
  import instr_cache_ctrl_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS,
  parameter int IDX_W = $clog2(LINES),
  parameter int OFF_W = $clog2(WORDS),
  parameter int TAG_W = tag_width(LINES, WORDS)
) (
  input  logic              clk,
  input  logic              reset_ms,
  input  logic              clr_all,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              set_valid,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_word,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data
);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [DATA_W-1:0] data [LINES*WORDS];

  // Valid bits: clear-all wins over a same-edge line fill
  always_ff @(posedge clk) begin
    if (reset_ms || clr_all) begin
      valid <= '0;
    end else if (set_valid) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag is written together with the valid bit
  always_ff @(posedge clk) begin
    if (set_valid) begin
      tags[wr_idx] <= wr_tag;
    end
  end

  // Data words are written one at a time during refill
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data[{wr_idx, wr_word}] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[{rd_idx, rd_word}];

endmodule

// File: rtl/instr_cache_ctrl.sv
// Direct-mapped instruction cache controller with
// zero-cycle hits and word-serial line refill.
module instr_cache_ctrl
  import instr_cache_ctrl_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic              clk,
  input  logic              reset_ms,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic [DATA_W-1:0] instr,
  output logic              stall,
  input  logic              flush,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = tag_width(LINES, WORDS);

  state_t state;
  state_t state_nx;

  logic [TAG_W-1:0] pc_tag;
  logic [IDX_W-1:0] pc_idx;
  logic [OFF_W-1:0] pc_word;
  logic [TAG_W-1:0] ref_tag;
  logic [IDX_W-1:0] ref_idx;
  logic [OFF_W-1:0] word;
  logic             flush_pend;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;

  logic hit;
  logic miss;
  logic last;
  logic wr_en;
  logic set_valid;
  logic clr_all;
  logic unused_bits;

  assign unused_bits = ^pc_addr[BYTE_W-1:0];

  assign pc_word = pc_addr[BYTE_W +: OFF_W];
  assign pc_idx  = pc_addr[BYTE_W+OFF_W +: IDX_W];
  assign pc_tag  = pc_addr[ADDR_W-1 -: TAG_W];

  assign hit  = !reset_ms && (state == IDLE) &&
                rd_valid && (rd_tag == pc_tag);
  assign last = (word == OFF_W'(WORDS-1));

  icache_array #(
    .LINES (LINES),
    .WORDS (WORDS),
    .IDX_W (IDX_W),
    .OFF_W (OFF_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk       (clk),
    .reset_ms  (reset_ms),
    .clr_all   (clr_all),
    .wr_en     (wr_en),
    .wr_idx    (ref_idx),
    .wr_word   (word),
    .wr_data   (mem_rdata),
    .set_valid (set_valid),
    .wr_tag    (ref_tag),
    .rd_idx    (pc_idx),
    .rd_word   (pc_word),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset_ms) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, core/memory outputs and array controls
  always_comb begin
    state_nx   = state;
    stall      = 1'b0;
    instr      = NOP;
    mem_rd_req = 1'b0;
    mem_addr   = '0;
    wr_en      = 1'b0;
    set_valid  = 1'b0;
    clr_all    = 1'b0;
    miss       = 1'b0;
    if (!reset_ms) begin
      unique case (state)
        IDLE: begin
          clr_all = flush;
          if (hit) begin
            instr = rd_data;
          end else begin
            stall    = 1'b1;
            miss     = 1'b1;
            state_nx = REFILL;
          end
        end
        REFILL: begin
          stall      = 1'b1;
          mem_addr   = {ref_tag, ref_idx, word, 2'b00};
          mem_rd_req = !mem_rvalid;
          wr_en      = mem_rvalid;
          if (mem_rvalid && last) begin
            set_valid = 1'b1;
            clr_all   = flush_pend || flush;
            state_nx  = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Line being refilled; only meaningful in REFILL
  always_ff @(posedge clk) begin
    if (miss) begin
      ref_tag <= pc_tag;
      ref_idx <= pc_idx;
    end
  end

  // Word pointer and deferred flush
  always_ff @(posedge clk) begin
    if (reset_ms) begin
      word       <= '0;
      flush_pend <= 1'b0;
    end else if (miss) begin
      word       <= '0;
      flush_pend <= 1'b0;
    end else if (state == REFILL) begin
      if (mem_rvalid) begin
        word <= word + 1'b1;
      end
      if (state_nx == IDLE) begin
        flush_pend <= 1'b0;
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

  // Saturating hit/miss counters
  always_ff @(posedge clk) begin
    if (reset_ms) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + 1'b1;
      end
      if (miss && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_cache_ctrl.sv
// Directed bench for instr_cache_ctrl with a
// fixed-latency backing-memory responder.
module tb_instr_cache_ctrl;

  localparam int LAT = 2;
  localparam logic [31:0] NOPI = 32'h00000013;

  logic        clk;
  logic        reset_ms;
  logic [31:0] pc_addr;
  logic [31:0] instr;
  logic        stall;
  logic        flush;
  logic        mem_rd_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  logic        model_rv;
  logic        spur;
  int          lat_cnt;
  int          checks;
  int          failures;
  int          stalls;
  logic [31:0] seen [$];

  assign mem_rvalid = model_rv | spur;

  instr_cache_ctrl dut (
    .clk        (clk),
    .reset_ms   (reset_ms),
    .pc_addr    (pc_addr),
    .instr      (instr),
    .stall      (stall),
    .flush      (flush),
    .mem_rd_req (mem_rd_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]} ^ {a[15:0], 16'h0000};
  endfunction

  // Memory answers after LAT consecutive request cycles
  always @(posedge clk) begin
    if (reset_ms || model_rv) begin
      model_rv <= 1'b0;
      lat_cnt  <= 0;
    end else if (mem_rd_req) begin
      if (lat_cnt == LAT-1) begin
        model_rv  <= 1'b1;
        mem_rdata <= mem_word(mem_addr);
        lat_cnt   <= 0;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a fetch and count stall cycles until it is served
  task automatic run_fetch(input logic [31:0] a, output int n);
    logic done;
    done = 1'b0;
    n = 0;
    seen.delete();
    pc_addr = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        break;
      end
      n++;
      chk("nop_in_stall", instr, NOPI);
      if (mem_rd_req &&
          (seen.size() == 0 || seen[seen.size()-1] != mem_addr))
        seen.push_back(mem_addr);
      tick();
    end
    checks++;
    assert (done === 1'b1) else begin
      failures++;
      $error("FAIL timeout observed=%0d expected=served", n);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_rv = 1'b0;
    lat_cnt  = 0;
    mem_rdata = '0;
    spur     = 1'b0;
    flush    = 1'b0;
    pc_addr  = '0;
    reset_ms = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_instr", instr, NOPI);
    chk("rst_req", {31'b0, mem_rd_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_hit", {16'b0, hit_cnt}, 32'd0);
    chk("rst_miss", {16'b0, miss_cnt}, 32'd0);
    tick();
    reset_ms = 1'b0;

    run_fetch(32'h0, stalls);
    chk("cold_stalls", stalls, 32'd13);
    chk("cold_naddr", seen.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < seen.size())
        chk("cold_addr", seen[i], 32'(i * 4));
    chk("cold_instr", instr, mem_word(32'h0));
    chk("cold_miss", {16'b0, miss_cnt}, 32'd1);

    tick();
    pc_addr = 32'h8;
    @(negedge clk);
    chk("hit8_stall", {31'b0, stall}, 32'd0);
    chk("hit8_instr", instr, mem_word(32'h8));
    chk("hit8_req", {31'b0, mem_rd_req}, 32'd0);
    chk("hit8_cnt", {16'b0, hit_cnt}, 32'd1);

    tick();
    run_fetch(32'h100, stalls);
    chk("conf_stalls", stalls, 32'd13);
    chk("conf_addr0", seen.size() > 0 ? seen[0] : 32'hX, 32'h100);
    chk("conf_instr", instr, mem_word(32'h100));
    chk("conf_miss", {16'b0, miss_cnt}, 32'd2);
    tick();
    run_fetch(32'h0, stalls);
    chk("remiss_stalls", stalls, 32'd13);
    chk("remiss_miss", {16'b0, miss_cnt}, 32'd3);
    chk("remiss_hit", {16'b0, hit_cnt}, 32'd3);

    tick();
    pc_addr = 32'h200;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 6) begin
        chk("mid_rvalid", {31'b0, mem_rvalid}, 32'd1);
        chk("mid_addr", mem_addr, 32'h204);
      end
      tick();
    end
    reset_ms = 1'b1;
    @(negedge clk);
    chk("abort_stall", {31'b0, stall}, 32'd0);
    chk("abort_req", {31'b0, mem_rd_req}, 32'd0);
    chk("abort_instr", instr, NOPI);
    tick();
    reset_ms = 1'b0;
    run_fetch(32'h200, stalls);
    chk("abort_stalls", stalls, 32'd13);
    chk("abort_miss", {16'b0, miss_cnt}, 32'd1);
    chk("abort_data", instr, mem_word(32'h200));

    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_served", {31'b0, stall}, 32'd0);
    chk("flush_instr", instr, mem_word(32'h200));
    tick();
    flush = 1'b0;
    run_fetch(32'h200, stalls);
    chk("flush_stalls", stalls, 32'd13);
    chk("flush_miss", {16'b0, miss_cnt}, 32'd2);

    tick();
    pc_addr = 32'h300;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) flush = 1'b1;
      @(negedge clk);
      chk("rflush_stall", {31'b0, stall}, 32'd1);
      tick();
      flush = 1'b0;
    end
    run_fetch(32'h300, stalls);
    chk("rflush_stalls", stalls, 32'd23);
    chk("rflush_miss", {16'b0, miss_cnt}, 32'd4);
    chk("rflush_instr", instr, mem_word(32'h300));

    tick();
    spur = 1'b1;
    @(negedge clk);
    chk("spur_stall", {31'b0, stall}, 32'd0);
    chk("spur_req", {31'b0, mem_rd_req}, 32'd0);
    tick();
    spur = 1'b0;
    @(negedge clk);
    chk("spur_instr", instr, mem_word(32'h300));
    chk("spur_stall2", {31'b0, stall}, 32'd0);

    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("hit_sat", {16'b0, hit_cnt}, 32'h0000FFFF);
    chk("miss_hold", {16'b0, miss_cnt}, 32'd4);
    chk("sat_instr", instr, mem_word(32'h300));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
